lsu_unit: RTL and testbench
===========================

// Module: lsu_unit
// PURPOSE
//  Load/store unit placed directly downstream of the RV32I core's ALU. It takes the ALU address, rs2 data and
//  funct3, and runs one byte/half/word access on a word-addressed, byte-enabled data memory over a req/ack
//  handshake. It returns sign- or zero-extended load data for register writeback, or a fault.
// PARAMETERS
//  ADDR_W   12   word-address width of mem_addr (taken from req_addr[ADDR_W+1:2])
//  TIMEOUT  255  cycles to wait for mem_ack before faulting; 0 = wait forever
// PORTS
//  clk         in   1       clock, all state on posedge
//  reset       in   1       asynchronous, active-high
//  req_valid   in   1       core presents an access
//  req_ready   out  1       high only in IDLE; accept = req_valid & req_ready
//  req_we      in   1       1 = store, 0 = load
//  req_funct3  in   3       RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  req_addr    in   32      byte address (ALU result)
//  req_wdata   in   32      store data (rs2)
//  rsp_valid   out  1       one-cycle completion pulse
//  rsp_rdata   out  32      extended load data, valid with rsp_valid; 0 for stores/faults
//  rsp_fault   out  1       valid with rsp_valid: illegal funct3, misaligned or timeout
//  mem_req     out  1       memory request, held until mem_ack
//  mem_we      out  1       write strobe qualifier
//  mem_addr    out  ADDR_W  word address
//  mem_be      out  4       byte enables; bit i = byte lane i ([8i+7:8i])
//  mem_wdata   out  32      lane-aligned store data
//  mem_ack     in   1       completes access; mem_rdata valid in same cycle
//  mem_rdata   in   32      read word
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except req_ready=1; timeout counter 0. A reset mid-access drops mem_req
//   immediately and discards the transaction; no rsp_valid follows.
//  FSM IDLE -> ACCESS on accept of a legal, aligned request: capture we/funct3/addr/wdata, assert mem_req next cycle.
//      IDLE -> RESP on accept of an illegal/misaligned request (fault=1, no mem_req ever asserted).
//      ACCESS -> RESP when mem_ack=1, capturing the extended rdata; ACCESS -> RESP with fault on timeout.
//      RESP -> IDLE unconditionally; rsp_valid=1 only in RESP.
//  Latency: accept at cycle N, mem_req from N+1, ack at N+1+k (k>=0), rsp_valid at N+2+k. Fault path: rsp_valid at N+1.
//  mem_req/mem_we/mem_addr/mem_be/mem_wdata are registered and stable for the whole ACCESS phase; 0 outside it.
//  mem_ack outside ACCESS is ignored. req_valid outside IDLE is not accepted.
//  Legal funct3: load 000,001,010,100,101; store 000,001,010. Anything else is a fault regardless of the macro.
//  Byte lane: off = addr[1:0]. SB: be = 1<<off, wdata = {4{byte}}. SH: be = 0011 (off=0) or 1100 (off=2),
//   wdata = {2{half}}. SW: be = 1111. Loads drive be = 1111 and mem_we = 0.
//  Load extract: rdata >> (8*off), then take byte/half; funct3[2]=0 sign-extends, 1 zero-extends; LW passes the word.
//  Timeout: counter clears on ACCESS entry and increments each ACCESS cycle without ack; reaching TIMEOUT -> fault.
//   An ack in the same cycle the counter reaches TIMEOUT wins (no fault).
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: a half with off[0]=1 or a word with off!=0 faults via IDLE->RESP, with no memory access.
//  Not defined: misaligned addresses are force-aligned (half: off[0] cleared; word: off cleared) and the access
//   proceeds normally; rsp_fault then comes only from illegal funct3 or timeout.
// TESTING
//  LW addr=0x10, mem_rdata=0xDEADBEEF, ack after 2 cycles -> mem_addr=4, be=1111, rsp_rdata=0xDEADBEEF, rsp at N+4.
//  LB addr=0x13 / LBU addr=0x13, rdata=0x80FF0000 -> rsp_rdata=0xFFFFFF80 / 0x00000080.
//  SH addr=0x22, wdata=0x1234ABCD -> mem_we=1, be=1100, mem_wdata=0xABCDABCD, rsp_fault=0.
//  LW addr=0x06: macro on -> rsp_fault=1 at N+1, mem_req never high; macro off -> mem_addr=1, be=1111.
//  TIMEOUT=4, no ack -> rsp_valid with rsp_fault=1 four cycles into ACCESS; reset asserted mid-ACCESS -> mem_req=0 at once.
//  funct3=011 load and funct3=100 store -> fault, no mem_req; back-to-back requests accepted only while req_ready=1.

Source files
------------

// File: rtl/lsu_if.sv
// lsu_if: core request/response and data-memory signals of the load/store unit.
// master = core + memory side, slave = the LSU.
interface lsu_if #(parameter int ADDR_W = 12);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_fault;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_unit.sv
// lsu_unit: RV32I byte/half/word load/store unit over a req/ack, byte-enabled word memory.
// LSU_MISALIGN_TRAP_EN: fault misaligned accesses instead of force-aligning them.
module lsu_unit #(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 255
) (
  input logic  clk,
  input logic  reset,
  lsu_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam int CW = $clog2(TIMEOUT + 2);
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d, st_be;
  logic [31:0]       mem_wdata_q, mem_wdata_d, st_wdata;
  logic              rsp_valid_q, rsp_valid_d, rsp_fault_q, rsp_fault_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d, ext;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d, off, eoff;
  logic [15:0]       shifted;
  logic              legal, half, word, bad, timed_out;
  always_comb begin
    off   = bus.req_addr[1:0];
    half  = bus.req_funct3[1:0] == 2'b01;
    word  = bus.req_funct3[1:0] == 2'b10;
    legal = bus.req_we ? (bus.req_funct3 inside {3'b000, 3'b001, 3'b010})
                       : !(bus.req_funct3 inside {3'b011, 3'b110, 3'b111});
`ifdef LSU_MISALIGN_TRAP_EN
    bad  = !legal | (half & off[0]) | (word & (|off));
    eoff = off;
`else
    bad  = !legal;
    eoff = word ? 2'b00 : half ? {off[1], 1'b0} : off;
`endif
    st_be     = word ? 4'hF : half ? (eoff[1] ? 4'hC : 4'h3) : 4'b0001 << eoff;
    st_wdata  = word ? bus.req_wdata : half ? {2{bus.req_wdata[15:0]}} : {4{bus.req_wdata[7:0]}};
    shifted   = 16'(bus.mem_rdata >> {off_q, 3'b000});
    ext       = f3_q[1] ? bus.mem_rdata
              : f3_q[0] ? {{16{~f3_q[2] & shifted[15]}}, shifted[15:0]}
                        : {{24{~f3_q[2] & shifted[7]}}, shifted[7:0]};
    cnt_inc   = cnt_q + 1'b1;
    timed_out = (TIMEOUT != 0) && (cnt_inc == CW'(TIMEOUT));
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    f3_d        = f3_q;
    off_d       = off_q;
    rsp_valid_d = 1'b0;
    rsp_fault_d = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        if (bad) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_fault_d = 1'b1;
        end else begin
          state_d     = ACCESS;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.req_we;
          mem_addr_d  = bus.req_addr[ADDR_W+1:2];
          mem_be_d    = bus.req_we ? st_be : 4'hF;
          mem_wdata_d = bus.req_we ? st_wdata : '0;
          f3_d        = bus.req_funct3;
          off_d       = eoff;
        end
      end
      ACCESS: if (bus.mem_ack || timed_out) begin
        // an ack on the timeout cycle still completes the access cleanly
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_fault_d = !bus.mem_ack;
        rsp_rdata_d = (bus.mem_ack && !mem_we_q) ? ext : '0;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_be_d    = '0;
        mem_wdata_d = '0;
      end else begin
        cnt_d = cnt_inc;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      f3_q        <= '0;
      off_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_fault_q <= rsp_fault_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end
  assign bus.req_ready = state_q == IDLE;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_fault = rsp_fault_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_lsu_unit.sv
// tb_lsu_unit: directed and random load/store accesses checked against an arithmetic model of the LSU.
module tb_lsu_unit;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic reset;
  lsu_if #(.ADDR_W(12)) bus();
  lsu_unit #(.ADDR_W(12), .TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int n_assert = 0;
  int n_fail = 0;
  logic [31:0] last_rdata, last_wd;
  logic [3:0]  last_be;
  logic        last_fault;
  int          last_lat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a, wd, rd,
                                output logic flt, output logic [3:0] be, output logic [31:0] mwd,
                                output logic [11:0] maddr, output logic [31:0] res);
    int sz, off;
    logic legal, mis;
    logic [63:0] v;
    sz    = 1 << f3[1:0];
    legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 < 3'd6);
    off   = int'(a % 4);
    mis   = (off % sz) != 0;
`ifdef LSU_MISALIGN_TRAP_EN
    flt = !legal || mis;
`else
    flt = !legal;
    off = off - (off % sz);
`endif
    be  = we ? 4'(((1 << sz) - 1) << off) : 4'hF;
    mwd = '0;
    if (we) for (int i = 0; i < 4; i++) mwd[8*i +: 8] = wd[8*(i % sz) +: 8];
    maddr = 12'(a >> 2);
    v = (64'(rd) >> (8 * off)) & ((64'd1 << (8 * sz)) - 64'd1);
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v - (64'd1 << (8 * sz));
    res = we ? 32'd0 : v[31:0];
  endfunction

  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a, wd, rd,
                        input int k, input logic hold);
    logic eflt, acked;
    logic [3:0] ebe;
    logic [31:0] ewd, eres;
    logic [11:0] ead;
    model(we, f3, a, wd, rd, eflt, ebe, ewd, ead, eres);
    @(negedge clk);
    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.mem_ack    = 1'($urandom);
    @(negedge clk);
    bus.mem_ack   = 1'b0;
    bus.req_valid = hold;
    if (hold) begin
      bus.req_addr  = $urandom;
      bus.req_wdata = $urandom;
    end
    last_lat = 1;
    acked = 1'b0;
    last_be = 4'h0;
    last_wd = 32'h0;
    if (eflt) begin
      chk("fault_mem_req", 32'(bus.mem_req), 32'd0);
    end else begin
      last_be = bus.mem_be;
      last_wd = bus.mem_wdata;
      for (int c = 0; c < TO && !acked; c++) begin
        chk("mem_req", 32'(bus.mem_req), 32'd1);
        chk("mem_we", 32'(bus.mem_we), 32'(we));
        chk("mem_addr", 32'(bus.mem_addr), 32'(ead));
        chk("mem_be", 32'(bus.mem_be), 32'(ebe));
        chk("mem_wdata", bus.mem_wdata, ewd);
        chk("rsp_early", 32'(bus.rsp_valid), 32'd0);
        chk("busy_ready", 32'(bus.req_ready), 32'd0);
        if (c == k) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = rd;
          acked = 1'b1;
        end
        @(negedge clk);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = $urandom;
        last_lat++;
      end
      chk("done_mem_req", 32'(bus.mem_req), 32'd0);
    end
    chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("rsp_fault", 32'(bus.rsp_fault), 32'(eflt || !acked));
    chk("rsp_rdata", bus.rsp_rdata, acked ? eres : 32'd0);
    last_rdata = bus.rsp_rdata;
    last_fault = bus.rsp_fault;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rsp_pulse", 32'(bus.rsp_valid), 32'd0);
    chk("back_idle", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr = 32'd0;
    bus.req_wdata = 32'd0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 32'd0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_fault", 32'(bus.rsp_fault), 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_be", 32'(bus.mem_be), 32'd0);
    reset = 1'b0;
    access(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 2, 1'b0);
    chk("lw_data", last_rdata, 32'hDEADBEEF);
    chk("lw_latency", 32'(last_lat), 32'd4);
    access(1'b0, 3'b000, 32'h13, 32'h0, 32'h80FF0000, 0, 1'b0);
    chk("lb_sext", last_rdata, 32'hFFFFFF80);
    access(1'b0, 3'b100, 32'h13, 32'h0, 32'h80FF0000, 1, 1'b1);
    chk("lbu_zext", last_rdata, 32'h00000080);
    access(1'b1, 3'b001, 32'h22, 32'h1234ABCD, 32'h0, 0, 1'b0);
    chk("sh_be", 32'(last_be), 32'hC);
    chk("sh_wdata", last_wd, 32'hABCDABCD);
    chk("sh_fault", 32'(last_fault), 32'd0);
    access(1'b0, 3'b010, 32'h06, 32'h0, 32'h11223344, 0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw_mis_fault", 32'(last_fault), 32'd1);
    chk("lw_mis_lat", 32'(last_lat), 32'd1);
`else
    chk("lw_mis_be", 32'(last_be), 32'hF);
    chk("lw_mis_data", last_rdata, 32'h11223344);
`endif
    access(1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 99, 1'b0);
    chk("timeout_fault", 32'(last_fault), 32'd1);
    chk("timeout_lat", 32'(last_lat), 32'(TO + 1));
    access(1'b0, 3'b101, 32'h42, 32'h0, 32'h8001_0000, TO - 1, 1'b0);
    chk("ack_on_timeout", 32'(last_fault), 32'd0);
    chk("lhu_data", last_rdata, 32'h00008001);
    access(1'b0, 3'b011, 32'h8, 32'h0, 32'h0, 0, 1'b0);
    chk("ld011_fault", 32'(last_fault), 32'd1);
    access(1'b1, 3'b100, 32'h8, 32'h55, 32'h0, 0, 1'b0);
    chk("st100_fault", 32'(last_fault), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h20;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_mem_req", 32'(bus.mem_req), 32'd1);
    #2 reset = 1'b1;
    #1 chk("async_rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("async_rst_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    for (int i = 0; i < 60; i++)
      access(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom, int'($urandom_range(0, TO)), 1'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
